scan_chain_loader: RTL and testbench
====================================

Name: scan_chain_loader

Overview:
Sequences the PE-array configuration scan chains from BRAM before each layer. On start, reads a contiguous configuration image via the IARG BRAM port and shifts it into four chains, one word per cycle: the ID chain, the row chain, the LN config and the PE config. Sits between the top-level controller (start/done, base address from the scan-chain scalar) and the PEArray scan-chain inputs.

Parameters:
ADDRESS_BITWIDTH, 32, BRAM byte-address width
DATA_BITWIDTH, 32, BRAM data width
XBUS_NUMS, 12, X-buses (rows) in PE array
PE_NUMS, 14, PEs per X-bus
ID_LEN, 5, ID scan entry width
ROW_LEN, 4, row scan entry width
PE_CONFIG_BIT, 32, PE config word width (must be <= DATA_BITWIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin load
base_address  in  ADDRESS_BITWIDTH  byte address of image word 0; sampled on accepted start
busy  out  1  high from first read until last shift
done  out  1  one-cycle pulse after last shift
ram_address  out  ADDRESS_BITWIDTH  BRAM read address
ram_enable  out  1  BRAM read enable
ram_we  out  4  always 0
ram_rdata  in  DATA_BITWIDTH  BRAM read data, valid one cycle after enable
set_id  out  1  ID chain shift strobe
id_scan_in  out  ID_LEN  ID chain data
set_row  out  1  row chain shift strobe
row_scan_in  out  ROW_LEN  row chain data
set_ln_info  out  1  LN config load strobe
LN_config_in  out  XBUS_NUMS  LN config data
set_pe_info  out  1  PE config load strobe
pe_config_in  out  PE_CONFIG_BIT  PE config data

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Image layout, one entry per 32-bit word at base + 4*i, low bits used:
  - N_ID = XBUS_NUMS*PE_NUMS ID words
  - then XBUS_NUMS row words
  - then 1 LN word
  - then 1 PE word
  - Total T = N_ID+XBUS_NUMS+2 (182 at defaults).
- Address arithmetic: base + 4*i, modulo 2^ADDRESS_BITWIDTH (wraps silently). Word counter is sized by $clog2(T+1).
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 latches base, goes to READ. start is ignored in every other state.
  - READ: issues one read per cycle (ram_enable=1, ram_address=base+4*i), i = 0..T-1. After issuing i=T-1, goes to DRAIN.
  - DRAIN: waits until the final strobe is output, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Pipeline: read issued in cycle k, ram_rdata sampled at end of cycle k+1, strobe+data registered and visible in cycle k+2.
- Timing, with start seen in cycle 0: reads in cycles 1..T; strobes in 3..T+2; done in T+3; busy high in cycles 1..T+2.
- Strobe order, exactly one strobe high per cycle, contiguous:
  - set_id for N_ID cycles, id_scan_in=rdata[ID_LEN-1:0]
  - set_row for XBUS_NUMS cycles, row_scan_in=rdata[ROW_LEN-1:0]
  - set_ln_info 1 cycle, LN_config_in=rdata[XBUS_NUMS-1:0]
  - set_pe_info 1 cycle, pe_config_in=rdata[PE_CONFIG_BIT-1:0]
- Strobe selection uses the word index carried down the pipeline, not the FSM state.
- Data outputs hold their last value when their strobe is low; they are zero after reset.
- Reset values: all strobes, ram_enable, busy, done, ram_we = 0; ram_address = 0; FSM = IDLE.
- rst mid-load: next cycle all strobes and ram_enable are 0, the in-flight read is discarded, and no done pulse is issued. The PE array holds a partially shifted chain; software must reload.
- start asserted in the same cycle as done: ignored (FSM not yet IDLE).

Optional Feature:
SCAN_LOADER_SKIP_IDS_EN
- Enabled: adds input skip_ids (1 bit), sampled with start. If 1, reads start at word index N_ID+XBUS_NUMS: only the LN and PE words are read, T=2, and no set_id/set_row strobes are issued. Address is base+4*(N_ID+XBUS_NUMS).
- Disabled: the port is absent and the full image is always loaded.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy=0.
- start with base=0x1000, BRAM word i = i -> 168 set_id cycles with id_scan_in = i[4:0]; then 12 set_row cycles with values 168..179 [3:0]; LN_config_in=180; pe_config_in=181. done in cycle 185; last ram_address=0x12D4.
- base=0xFFFFFFFC -> second read address 0x00000000 (wrap); load completes normally.
- start pulsed again in cycle 50 of a load -> ignored; exactly 182 reads; single done.
- rst asserted in cycle 100 -> cycle 101 all strobes=0, busy=0; no done; a new start afterwards gives a full 182-word load.
- SCAN_LOADER_SKIP_IDS_EN, skip_ids=1, base=0 -> reads 0x2D0 and 0x2D4 only; set_ln_info in cycle 3, set_pe_info in cycle 4, done in cycle 5; no set_id/set_row.

Source files
------------

// File: rtl/scan_chain_loader.sv
// Streams a PE-array configuration image from BRAM into the ID, row, LN and PE chains.
// Ports: clk/rst, start/base_address/busy/done, BRAM read port, chain strobes+data; optional skip_ids (SCAN_LOADER_SKIP_IDS_EN).
module scan_chain_loader #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32,
  parameter int XBUS_NUMS        = 12,
  parameter int PE_NUMS          = 14,
  parameter int ID_LEN           = 5,
  parameter int ROW_LEN          = 4,
  parameter int PE_CONFIG_BIT    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDRESS_BITWIDTH-1:0] base_address,
`ifdef SCAN_LOADER_SKIP_IDS_EN
  input  logic                        skip_ids,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [ADDRESS_BITWIDTH-1:0] ram_address,
  output logic                        ram_enable,
  output logic [3:0]                  ram_we,
  input  logic [DATA_BITWIDTH-1:0]    ram_rdata,
  output logic                        set_id,
  output logic [ID_LEN-1:0]           id_scan_in,
  output logic                        set_row,
  output logic [ROW_LEN-1:0]          row_scan_in,
  output logic                        set_ln_info,
  output logic [XBUS_NUMS-1:0]        LN_config_in,
  output logic                        set_pe_info,
  output logic [PE_CONFIG_BIT-1:0]    pe_config_in
);

  localparam int N_ID = XBUS_NUMS * PE_NUMS;
  localparam int TOT  = N_ID + XBUS_NUMS + 2;
  localparam int CW   = $clog2(TOT + 1);
  localparam int AW   = ADDRESS_BITWIDTH;

  localparam logic [CW-1:0] ROW0   = CW'(N_ID);
  localparam logic [CW-1:0] LN_IDX = CW'(N_ID + XBUS_NUMS);
  localparam logic [CW-1:0] LAST   = CW'(TOT - 1);
  localparam logic [AW-1:0] SKIP_OFF = AW'(4 * (N_ID + XBUS_NUMS));

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [CW-1:0] rd_idx;
  logic          v1;
  logic [CW-1:0] idx1;
  logic          rd_last;
  logic          skip_w;
  logic          sel_id, sel_row, sel_ln, sel_pe;

`ifdef SCAN_LOADER_SKIP_IDS_EN
  assign skip_w = skip_ids;
`else
  assign skip_w = 1'b0;
`endif

  assign rd_last     = (rd_idx == LAST);
  assign ram_enable  = (state_q == READ);
  assign ram_address = addr_q;
  assign ram_we      = 4'b0000;
  assign busy        = (state_q == READ) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rd_last) state_d = DRAIN;
      DRAIN:   if (set_pe_info) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Chain selection follows the index of the word now on ram_rdata,
  // so the strobes stay correct regardless of where the FSM is.
  always_comb begin
    sel_id  = 1'b0;
    sel_row = 1'b0;
    sel_ln  = 1'b0;
    sel_pe  = 1'b0;
    unique case (1'b1)
      (idx1 < ROW0):                  sel_id  = 1'b1;
      (idx1 >= ROW0 && idx1 < LN_IDX): sel_row = 1'b1;
      (idx1 == LN_IDX):               sel_ln  = 1'b1;
      default:                        sel_pe  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      rd_idx       <= '0;
      v1           <= 1'b0;
      idx1         <= '0;
      set_id       <= 1'b0;
      set_row      <= 1'b0;
      set_ln_info  <= 1'b0;
      set_pe_info  <= 1'b0;
      id_scan_in   <= '0;
      row_scan_in  <= '0;
      LN_config_in <= '0;
      pe_config_in <= '0;
    end else begin
      v1   <= ram_enable;
      idx1 <= rd_idx;
      if (state_q == IDLE && start) begin
        addr_q <= skip_w ? base_address + SKIP_OFF : base_address;
        rd_idx <= skip_w ? LN_IDX : '0;
      end else if (state_q == READ && !rd_last) begin
        addr_q <= addr_q + AW'(4);
        rd_idx <= rd_idx + CW'(1);
      end
      set_id      <= v1 & sel_id;
      set_row     <= v1 & sel_row;
      set_ln_info <= v1 & sel_ln;
      set_pe_info <= v1 & sel_pe;
      if (v1 && sel_id)  id_scan_in   <= ram_rdata[ID_LEN-1:0];
      if (v1 && sel_row) row_scan_in  <= ram_rdata[ROW_LEN-1:0];
      if (v1 && sel_ln)  LN_config_in <= ram_rdata[XBUS_NUMS-1:0];
      if (v1 && sel_pe)  pe_config_in <= ram_rdata[PE_CONFIG_BIT-1:0];
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Self-checking bench for scan_chain_loader.
// Per-cycle output records are compared against a word-index model of the load.
module tb_scan_chain_loader;

  localparam int NID = 12 * 14;
  localparam int TF  = NID + 12 + 2;
  localparam int NC  = TF + 6;

  typedef logic [95:0] rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_address = '0;
`ifdef SCAN_LOADER_SKIP_IDS_EN
  logic        skip = 1'b0;
`endif
  logic        busy, done, ram_enable;
  logic [31:0] ram_address;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata = '0;
  logic        set_id, set_row, set_ln_info, set_pe_info;
  logic [4:0]  id_scan_in;
  logic [3:0]  row_scan_in;
  logic [11:0] LN_config_in;
  logic [31:0] pe_config_in;

  logic [31:0] cur_base = '0;
  logic [31:0] salt = '0;
  int errors = 0;
  int checks = 0;

  logic [4:0]  h_id = '0;
  logic [3:0]  h_row = '0;
  logic [11:0] h_ln = '0;
  logic [31:0] h_pe = '0;

  rec_t obs   [0:NC-1];
  rec_t exp_r [0:NC-1];

  always #5 clk = ~clk;

  scan_chain_loader dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_address(base_address),
`ifdef SCAN_LOADER_SKIP_IDS_EN
    .skip_ids(skip),
`endif
    .busy(busy),
    .done(done),
    .ram_address(ram_address),
    .ram_enable(ram_enable),
    .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .set_id(set_id),
    .id_scan_in(id_scan_in),
    .set_row(set_row),
    .row_scan_in(row_scan_in),
    .set_ln_info(set_ln_info),
    .LN_config_in(LN_config_in),
    .set_pe_info(set_pe_info),
    .pe_config_in(pe_config_in)
  );

  // BRAM: word at base+4*w holds w ^ salt.
  always @(posedge clk)
    if (ram_enable)
      ram_rdata <= ((ram_address - cur_base) >> 2) ^ salt;

  function automatic rec_t observe();
    return {busy, done, ram_enable, ram_we,
            set_id, set_row, set_ln_info, set_pe_info,
            ram_enable ? ram_address : 32'h0,
            id_scan_in, row_scan_in, LN_config_in, pe_config_in};
  endfunction

  task automatic run_load(input logic [31:0] b, input logic [31:0] s,
                          input logic sk, input int rs_cyc,
                          input int rst_cyc, input int n);
    cur_base = b;
    salt = s;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == rs_cyc);
      base_address = (c == 0) ? b : $urandom;
`ifdef SCAN_LOADER_SKIP_IDS_EN
      skip = (c == 0) ? sk : 1'($urandom);
`endif
      rst = (c == rst_cyc);
      @(negedge clk);
      obs[c] = observe();
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
  endtask

  // Expected behaviour from the image layout and timing rules:
  // read of word f0+c-1 in cycle c, its strobe two cycles later.
  task automatic model(input logic [31:0] b, input logic [31:0] s,
                       input logic sk, input int rst_cyc, input int n);
    int teff, f0, w;
    logic bz, dn, en, si, sr, sl, sp;
    logic [31:0] a, d;
    teff = sk ? 2 : TF;
    f0 = sk ? NID + 12 : 0;
    for (int c = 0; c < n; c++) begin
      if (rst_cyc >= 0 && c > rst_cyc) begin
        h_id = '0; h_row = '0; h_ln = '0; h_pe = '0;
        exp_r[c] = '0;
      end else begin
        bz = (c >= 1) && (c <= teff + 2);
        dn = (c == teff + 3);
        en = (c >= 1) && (c <= teff);
        a  = en ? b + 32'(4 * (f0 + c - 1)) : 32'h0;
        si = 0; sr = 0; sl = 0; sp = 0;
        if (c >= 3 && c <= teff + 2) begin
          w = f0 + c - 3;
          d = 32'(w) ^ s;
          if (w < NID) begin si = 1; h_id = d[4:0]; end
          else if (w < NID + 12) begin sr = 1; h_row = d[3:0]; end
          else if (w == NID + 12) begin sl = 1; h_ln = d[11:0]; end
          else begin sp = 1; h_pe = d; end
        end
        exp_r[c] = {bz, dn, en, 4'b0000, si, sr, sl, sp, a,
                    h_id, h_row, h_ln, h_pe};
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (observe() !== 96'h0 || ram_address !== 32'h0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h addr=%h want all zero",
                 c, observe(), ram_address);
      end
    end
  endtask

  task automatic test_index_load();
    int nrd, ndn;
    run_load(32'h1000, 32'h0, 1'b0, -1, -1, NC);
    model(32'h1000, 32'h0, 1'b0, -1, NC);
    nrd = 0; ndn = 0;
    for (int c = 0; c < NC; c++) begin
      nrd += int'(obs[c][93]);
      ndn += int'(obs[c][94]);
      checks++;
      if (obs[c] !== exp_r[c]) begin
        errors++;
        $display("FAIL index_load cyc=%0d got=%h want=%h", c, obs[c], exp_r[c]);
      end
    end
    checks++;
    if (nrd !== TF || ndn !== 1 || obs[TF+3][94] !== 1'b1 ||
        obs[TF][84:53] !== 32'h12D4) begin
      errors++;
      $display("FAIL index_summary reads=%0d dones=%0d done185=%b last=%h want 182/1/1/12d4",
               nrd, ndn, obs[TF+3][94], obs[TF][84:53]);
    end
  endtask

  task automatic test_load(input string nm, input logic [31:0] b,
                           input logic sk, input int rs_cyc,
                           input int rst_cyc, input int n);
    logic [31:0] s;
    s = $urandom;
    run_load(b, s, sk, rs_cyc, rst_cyc, n);
    model(b, s, sk, rst_cyc, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs[c] !== exp_r[c]) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, obs[c], exp_r[c]);
      end
    end
  endtask

  task automatic test_wrap();
    test_load("wrap", 32'hFFFF_FFFC, 1'b0, -1, -1, NC);
    checks++;
    if (obs[2][84:53] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got=%h want=00000000", obs[2][84:53]);
    end
  endtask

  task automatic test_restart();
    test_load("restart", {$urandom} & 32'hFFFF_FFFC, 1'b0, 50, -1, NC);
  endtask

  task automatic test_back_to_back();
    test_load("b2b_first", {$urandom} & 32'hFFFF_FFFC, 1'b0, TF + 3, -1, NC);
    test_load("b2b_second", {$urandom} & 32'hFFFF_FFFC, 1'b0, -1, -1, NC);
  endtask

  task automatic test_reset_mid();
    test_load("rst_mid", 32'h2000, 1'b0, -1, 100, NC);
    test_load("after_rst", {$urandom} & 32'hFFFF_FFFC, 1'b0, -1, -1, NC);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++)
      test_load("random", $urandom, 1'b0, -1, -1, NC);
  endtask

`ifdef SCAN_LOADER_SKIP_IDS_EN
  task automatic test_skip();
    test_load("skip", 32'h0, 1'b1, -1, -1, 10);
    checks++;
    if (obs[1][84:53] !== 32'h2D0 || obs[2][84:53] !== 32'h2D4 ||
        obs[3][86] !== 1'b1 || obs[4][85] !== 1'b1 || obs[5][94] !== 1'b1) begin
      errors++;
      $display("FAIL skip_summary a1=%h a2=%h ln3=%b pe4=%b done5=%b want 2d0/2d4/1/1/1",
               obs[1][84:53], obs[2][84:53], obs[3][86], obs[4][85], obs[5][94]);
    end
    test_load("skip_rand", $urandom, 1'b1, -1, -1, 10);
  endtask
`endif

  initial begin
    test_reset();
    test_index_load();
    test_wrap();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SCAN_LOADER_SKIP_IDS_EN
    test_skip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
